// File: rtl/mipi_tx_frame_scheduler.sv
// mipi_tx_frame_scheduler: CSI-2 TX frame/line sequencer issuing FS, line and FE packet commands.
// Define LINE_SYNC_EN to wrap each line's long packet with LS/LE short packets.
module mipi_tx_frame_scheduler #(
   parameter logic [11:0] V_ACTIVE     = 12'd2688,
   parameter logic [15:0] H_TOTAL      = 16'd1400,
   parameter logic [19:0] V_BLANK_CLKS = 20'd20000,
   parameter logic [15:0] LINE_WC      = 16'd3240,
   parameter logic [5:0]  DATA_TYPE    = 6'h2B
)(
   input  logic        CLK_tx,
   input  logic        RSTn,
   input  logic        enable,
   output logic        vsync_o,
   output logic        hsync_o,
   output logic        frame_start_o,
   output logic        pkt_valid,
   output logic [5:0]  pkt_dt,
   output logic [15:0] pkt_wc,
   input  logic        pkt_ready,
   output logic [15:0] frame_cnt,
   output logic        busy,
   output logic        late_err
);
   localparam logic [2:0] S_IDLE = 3'd0, S_FS = 3'd1, S_LSTART = 3'd2, S_CMD = 3'd3,
                          S_WAIT = 3'd4, S_FE = 3'd5, S_VB = 3'd6;
   localparam logic [1:0] CMD_LS = 2'd0, CMD_DATA = 2'd1, CMD_LE = 2'd2;
`ifdef LINE_SYNC_EN
   localparam logic [1:0] FIRST_CMD = CMD_LS, LAST_CMD = CMD_LE;
`else
   localparam logic [1:0] FIRST_CMD = CMD_DATA, LAST_CMD = CMD_DATA;
`endif
   logic [2:0]  state_q, state_d;
   logic [1:0]  cmd_q, cmd_d;
   logic [15:0] h_cnt_q, h_cnt_d;
   logic [11:0] line_cnt_q, line_cnt_d;
   logic [19:0] blank_cnt_q, blank_cnt_d;
   logic [15:0] frame_num_q, frame_num_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        vsync_q, vsync_d;
   logic        frame_start_q, frame_start_d;
   logic        late_q, late_d;
   logic        accept, h_end, last_line, blank_end, start, line_done, cmd_last_acc;
   always_comb begin
      accept       = pkt_valid & pkt_ready;
      h_end        = h_cnt_q == H_TOTAL - 16'd1;
      last_line    = line_cnt_q + 12'd1 == V_ACTIVE;
      blank_end    = blank_cnt_q == V_BLANK_CLKS - 20'd2;
      start        = enable & ((state_q == S_IDLE) | (state_q == S_VB & blank_end));
      cmd_last_acc = state_q == S_CMD & accept & cmd_q == LAST_CMD;
      // a late line command jumps straight to the next line once accepted
      line_done    = (state_q == S_WAIT & h_end) | (cmd_last_acc & h_end);
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = enable ? S_FS : S_IDLE;
         S_FS:     state_d = accept ? S_LSTART : S_FS;
         S_LSTART: state_d = S_CMD;
         S_CMD:    state_d = line_done ? (last_line ? S_FE : S_LSTART) : cmd_last_acc ? S_WAIT : S_CMD;
         S_WAIT:   state_d = line_done ? (last_line ? S_FE : S_LSTART) : S_WAIT;
         S_FE:     state_d = accept ? S_VB : S_FE;
         S_VB:     state_d = blank_end ? (enable ? S_FS : S_IDLE) : S_VB;
         default:  state_d = S_IDLE;
      endcase
      cmd_d         = state_q == S_LSTART ? FIRST_CMD :
                      (state_q == S_CMD & accept & cmd_q != LAST_CMD) ? cmd_q + 2'd1 : cmd_q;
      h_cnt_d       = state_q == S_LSTART ? 16'd1 :
                      (state_q inside {S_CMD, S_WAIT}) & !h_end ? h_cnt_q + 16'd1 : h_cnt_q;
      line_cnt_d    = state_q == S_FS ? 12'd0 : line_done ? line_cnt_q + 12'd1 : line_cnt_q;
      blank_cnt_d   = state_q == S_VB ? blank_cnt_q + 20'd1 : 20'd0;
      frame_num_d   = start ? frame_num_q + 16'd1 : frame_num_q;
      vsync_d       = start;
      frame_start_d = (state_q == S_FS & accept) | (frame_start_q & !(state_q == S_FE & accept));
      frame_cnt_d   = (state_q == S_FE & accept) ? frame_cnt_q + 16'd1 : frame_cnt_q;
      late_d        = late_q | (state_q == S_CMD & h_end & !accept);
   end
   always_ff @(posedge CLK_tx or negedge RSTn)
      if (!RSTn) begin
         state_q       <= S_IDLE;
         cmd_q         <= CMD_LS;
         h_cnt_q       <= '0;
         line_cnt_q    <= '0;
         blank_cnt_q   <= '0;
         frame_num_q   <= '0;
         frame_cnt_q   <= '0;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
         late_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         h_cnt_q       <= h_cnt_d;
         line_cnt_q    <= line_cnt_d;
         blank_cnt_q   <= blank_cnt_d;
         frame_num_q   <= frame_num_d;
         frame_cnt_q   <= frame_cnt_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
         late_q        <= late_d;
      end
   always_comb begin
      vsync_o       = vsync_q;
      hsync_o       = state_q == S_LSTART;
      frame_start_o = frame_start_q;
      pkt_valid     = state_q inside {S_FS, S_CMD, S_FE};
      pkt_dt        = state_q == S_FE ? 6'h01 :
                      state_q != S_CMD ? 6'h00 :
                      cmd_q == CMD_LS ? 6'h02 : cmd_q == CMD_LE ? 6'h03 : DATA_TYPE;
      pkt_wc        = state_q inside {S_FS, S_FE} ? frame_num_q :
                      state_q != S_CMD ? 16'd0 :
                      cmd_q == CMD_DATA ? LINE_WC : {4'd0, line_cnt_q + 12'd1};
      frame_cnt     = frame_cnt_q;
      busy          = state_q != S_IDLE;
      late_err      = late_q;
   end
endmodule

// File: tb/tb_mipi_tx_frame_scheduler.sv
// tb_mipi_tx_frame_scheduler: directed checks with V_ACTIVE=4, H_TOTAL=16, V_BLANK_CLKS=10.
// Cycle numbers count edges since the last reset release; FS lands on cycle 1.
module tb_mipi_tx_frame_scheduler;
   logic        CLK_tx = 1'b0;
   logic        RSTn = 1'b0;
   logic        enable = 1'b0;
   logic        pkt_ready = 1'b1;
   logic        vsync_o, hsync_o, frame_start_o, pkt_valid, busy, late_err;
   logic [5:0]  pkt_dt;
   logic [15:0] pkt_wc, frame_cnt;
   int vectors = 0, errors = 0, cyc = 0, unstable = 0;
   int stall_len = 0, stall_tgt = -1, st_cnt = 0, cmd_idx = 0;
   logic pend = 1'b0;
   logic [5:0]  pend_dt;
   logic [15:0] pend_wc;
   int hs_t[$], vs_t[$], acc_t[$], acc_dt[$], acc_wc[$];

   mipi_tx_frame_scheduler #(.V_ACTIVE(12'd4), .H_TOTAL(16'd16), .V_BLANK_CLKS(20'd10)) dut (
      .CLK_tx(CLK_tx), .RSTn(RSTn), .enable(enable), .vsync_o(vsync_o), .hsync_o(hsync_o),
      .frame_start_o(frame_start_o), .pkt_valid(pkt_valid), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc),
      .pkt_ready(pkt_ready), .frame_cnt(frame_cnt), .busy(busy), .late_err(late_err));

   always #5 CLK_tx = ~CLK_tx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_logs();
      hs_t.delete(); vs_t.delete(); acc_t.delete(); acc_dt.delete(); acc_wc.delete();
      pend = 1'b0; st_cnt = 0; cmd_idx = 0;
   endtask

   // one cycle per iteration: drive ready for this cycle, then log what the DUT shows
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK_tx); #1; cyc++;
         if (pend && !(pkt_valid && pkt_dt == pend_dt && pkt_wc == pend_wc)) unstable++;
         pkt_ready = !(pkt_valid && (stall_tgt < 0 || stall_tgt == cmd_idx) && st_cnt < stall_len);
         if (!pkt_ready) st_cnt++;
         pend = pkt_valid && !pkt_ready; pend_dt = pkt_dt; pend_wc = pkt_wc;
         if (hsync_o) hs_t.push_back(cyc);
         if (vsync_o) vs_t.push_back(cyc);
         if (pkt_valid && pkt_ready) begin
            acc_t.push_back(cyc); acc_dt.push_back(int'(pkt_dt)); acc_wc.push_back(int'(pkt_wc));
            cmd_idx = (pkt_dt == 6'h01) ? 0 : cmd_idx + 1;
            st_cnt = 0;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, {26'd0, vsync_o, hsync_o, frame_start_o, pkt_valid, busy, late_err}, 32'd0);
      chk({tag, "_dt"}, pkt_dt, 32'd0);
      chk({tag, "_wc"}, pkt_wc, 32'd0);
      chk({tag, "_fcnt"}, frame_cnt, 32'd0);
   endtask

   task automatic do_reset();
      RSTn = 1'b0; enable = 1'b0; stall_len = 0; stall_tgt = -1;
      run(2);
      clear_logs();
      RSTn = 1'b1; cyc = 0;
   endtask

   initial begin
      int exp_dt[7], exp_wc[7], bad_dt;
      run(3);
      check_zero("reset");
      do_reset();
`ifdef LINE_SYNC_EN
      enable = 1'b1;
      run(70);
      chk("ls_count", acc_t.size(), 14);
      chk("ls_fs_dt", at(acc_dt, 0), 0);
      chk("ls_fs_wc", at(acc_wc, 0), 1);
      for (int l = 0; l < 4; l++) begin
         chk("ls_ls_dt", at(acc_dt, 1 + 3 * l), 2);
         chk("ls_ls_wc", at(acc_wc, 1 + 3 * l), l + 1);
         chk("ls_dat_dt", at(acc_dt, 2 + 3 * l), 43);
         chk("ls_dat_wc", at(acc_wc, 2 + 3 * l), 3240);
         chk("ls_le_dt", at(acc_dt, 3 + 3 * l), 3);
         chk("ls_le_wc", at(acc_wc, 3 + 3 * l), l + 1);
      end
      chk("ls_fe_dt", at(acc_dt, 13), 1);
      chk("ls_fe_t", at(acc_t, 13), 66);
      chk("ls_hs_spacing", at(hs_t, 3) - at(hs_t, 0), 48);
      chk("ls_late", late_err, 0);
`else
      // nominal frames, ready always high
      exp_dt = '{0, 43, 43, 43, 43, 1, 0};
      exp_wc = '{1, 3240, 3240, 3240, 3240, 1, 2};
      enable = 1'b1;
      run(40);
      chk("t1_frame_start", frame_start_o, 1);
      chk("t1_busy", busy, 1);
      run(36);
      chk("t1_vs_count", vs_t.size(), 2);
      chk("t1_vs0", at(vs_t, 0), 1);
      chk("t1_vs1", at(vs_t, 1), 76);
      chk("t1_hs_count", hs_t.size(), 4);
      chk("t1_hs0", at(hs_t, 0), 2);
      for (int i = 1; i < 4; i++) chk("t1_hs_period", at(hs_t, i) - at(hs_t, i - 1), 16);
      chk("t1_acc_count", acc_t.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk("t1_acc_dt", at(acc_dt, i), exp_dt[i]);
         chk("t1_acc_wc", at(acc_wc, i), exp_wc[i]);
      end
      chk("t1_fe_t", at(acc_t, 5), 66);
      chk("t1_blank_gap", at(acc_t, 6) - at(acc_t, 5), 10);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_frame_start_lo", frame_start_o, 0);
      bad_dt = 0;
      foreach (acc_dt[i]) if (acc_dt[i] == 2 || acc_dt[i] == 3) bad_dt++;
      chk("t1_no_ls_le", bad_dt, 0);
      // every command stalled 5 cycles
      do_reset();
      stall_len = 5; unstable = 0; enable = 1'b1;
      run(91);
      chk("t2_hs_count", hs_t.size(), 4);
      chk("t2_hs0", at(hs_t, 0), 7);
      for (int i = 1; i < 4; i++) chk("t2_hs_period", at(hs_t, i) - at(hs_t, i - 1), 16);
      chk("t2_acc_count", acc_t.size(), 7);
      chk("t2_fs_t", at(acc_t, 0), 6);
      chk("t2_l1_t", at(acc_t, 1), 13);
      chk("t2_fe_t", at(acc_t, 5), 76);
      chk("t2_fs2_t", at(acc_t, 6), 91);
      chk("t2_stable", unstable, 0);
      chk("t2_late", late_err, 0);
      // line 2 command stalled 20 cycles
      do_reset();
      stall_len = 20; stall_tgt = 2; enable = 1'b1;
      run(33);
      chk("t3_late_early", late_err, 0);
      run(7);
      chk("t3_l2_acc_t", at(acc_t, 2), 39);
      chk("t3_l3_hs", at(hs_t, 2), 40);
      chk("t3_late_set", late_err, 1);
      run(40);
      chk("t3_late_sticky", late_err, 1);
      chk("t3_hs_count", hs_t.size(), 4);
      chk("t3_l4_hs", at(hs_t, 3), 56);
      chk("t3_frame_cnt", frame_cnt, 1);
      // enable dropped during line 1
      do_reset();
      enable = 1'b1;
      run(2);
      enable = 1'b0;
      run(73);
      chk("t4_busy_vb", busy, 1);
      run(1);
      chk("t4_busy_off", busy, 0);
      chk("t4_frame_cnt", frame_cnt, 1);
      chk("t4_fe_dt", at(acc_dt, 5), 1);
      run(20);
      chk("t4_vs_count", vs_t.size(), 1);
      chk("t4_busy_idle", busy, 0);
      // asynchronous reset during LINE_WAIT
      do_reset();
      enable = 1'b1;
      run(10);
      clear_logs();
      RSTn = 1'b0;
      #1;
      check_zero("t5_async");
      run(3);
      chk("t5_no_fe", acc_t.size(), 0);
      RSTn = 1'b1; cyc = 0;
      run(1);
      chk("t5_vsync", vsync_o, 1);
      chk("t5_fs_dt", at(acc_dt, 0), 0);
      chk("t5_fs_wc", at(acc_wc, 0), 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
